axi4_mem_slave: RTL and testbench
=================================

Name: axi4_mem_slave

Overview:
AXI4 responder (subordinate) backed by an internal word-addressed storage array. It terminates one axi4_if.slave port and serves full AXI4 bursts (FIXED/INCR/WRAP) with byte strobes. Write and read channels run independent FSMs. Used as the on-chip scratch RAM and bus-functional endpoint behind crossbars and AXI4 initiators.

Parameters:
MEM_WORDS, 1024, storage depth in AXI4_DATA_WIDTH-bit words (power of 2, >=16)
BASE_ADDR, 0, byte base address of the window, aligned to MEM_WORDS*AXI4_DATA_WIDTH/8

Ports:
aclk  input  1  clock; all state on rising edge
aresetn  input  1  asynchronous active-low reset
axi  interface  axi4_if.slave  AXI4 port; widths set by AXI4_ID/ADDR/DATA/USER_WIDTH macros; module drives awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid

Behaviour:
- One clock (aclk). Reset is asynchronous, active-low (aresetn). Reset values: awready=0, wready=0, bvalid=0, bresp=0, bid=0, arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, rid=0. buser=ruser=0 always. Storage contents are not reset.
- awready/arready are registered: rise on the first aclk edge after reset release, then are high exactly while the owning FSM is idle.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On awvalid&awready, latch awid, awaddr, awlen, awsize, awburst. Beat counter=0, err=0. Go to W_DATA; awready=0 and wready=1 next cycle.
  - W_DATA: each wvalid&wready writes the wstrb-enabled bytes at the current beat address, then advances address and counter.
  - Burst ends on the beat where counter==awlen. wlast on any other beat, or missing on that beat, sets err; the write is still performed.
  - W_RESP: wready=0, bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if err else 2'b00. Hold until bready; then W_IDLE and awready=1 next cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - On arvalid&arready (cycle N), latch the AR fields. rvalid=1 at N+1 with beat 0 data, rid=arid.
  - rdata/rresp/rlast are registered and held stable while rvalid&!rready.
  - On rvalid&rready the next beat is presented the following cycle, giving 1 beat/cycle throughput. rlast=1 on beat arlen.
  - After the last handshake, rvalid=0 and arready=1 next cycle.
- Address generation (per channel), B=AXI4_DATA_WIDTH/8:
  - FIXED (00): address constant.
  - INCR (01): addr += 2^size.
  - WRAP (10): wrap boundary = (len+1)*2^size, aligned down; addr wraps within it. Legal only for len in {1,3,7,15}; otherwise err.
  - Burst 11, or size > log2(B): err.
  - Word index = (addr-BASE_ADDR)/B. Narrow transfers use the lanes given by the address; write lanes are wstrb only.
- Range: a beat with addr < BASE_ADDR or addr >= BASE_ADDR+MEM_WORDS*B gets SLVERR. An erroring write beat writes nothing. An erroring read beat returns rdata=0 with rresp=SLVERR (per-beat rresp); other beats of the same burst stay OKAY.
- awlock/arlock are ignored; exclusive accesses get OKAY, never EXOKAY. cache/prot/qos/region/user inputs are ignored.
- Simultaneous read and write to the same word in one cycle: read returns the pre-write data.
- Reset mid-burst: both FSMs return to idle, in-flight bursts are dropped with no response, and outputs take reset values immediately.

Test Plan:
Config for all scenarios: DATA_WIDTH=32, MEM_WORDS=256, BASE_ADDR=0.
1. Single write: awaddr=0x10, len=0, size=2, wdata=0xDEADBEEF, wstrb=0xF -> bvalid with bresp=00, bid=awid. Then read 0x10 -> rvalid exactly 1 cycle after AR handshake, rdata=0xDEADBEEF, rlast=1, rresp=00.
2. INCR write 4 beats at 0x20 (data 1,2,3,4), read back with rready toggling 1,0,1,0 -> rdata sequence 1,2,3,4 held stable while stalled; rlast only on 4th beat.
3. WRAP read: len=3, size=2, araddr=0x38 -> beat addresses 0x38,0x3C,0x30,0x34. WRAP len=2 -> all beats SLVERR.
4. Byte strobes: write 0xAABBCCDD wstrb=0x5 to word holding 0 -> readback 0x00BB00DD. Narrow write size=0 at 0x43, data lane 3=0x7E -> byte 3 of word 0x40 = 0x7E.
5. Errors: write to 0x400 (out of range) -> bresp=10, storage unchanged. Write len=3 with wlast on beat 2 -> bresp=10. INCR read 2 beats at 0x3FC -> rresp 00 then 10 with rdata=0.
6. Assert aresetn=0 mid-burst (beat 2 of 8 read) -> rvalid=0 immediately; arready=1 one edge after release; a new single read completes normally.

Source files
------------

// File: rtl/axi4_mem_slave_if.sv
// AXI4 bus bundle shared by initiators and responders.
// Widths come from the AXI4_*_WIDTH macros.
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

interface axi4_if;
   logic [`AXI4_ID_WIDTH-1:0]     awid;
   logic [`AXI4_ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]                    awlen;
   logic [2:0]                    awsize;
   logic [1:0]                    awburst;
   logic                          awlock;
   logic [3:0]                    awcache;
   logic [2:0]                    awprot;
   logic [3:0]                    awqos;
   logic [3:0]                    awregion;
   logic [`AXI4_USER_WIDTH-1:0]   awuser;
   logic                          awvalid;
   logic                          awready;

   logic [`AXI4_DATA_WIDTH-1:0]   wdata;
   logic [`AXI4_DATA_WIDTH/8-1:0] wstrb;
   logic                          wlast;
   logic [`AXI4_USER_WIDTH-1:0]   wuser;
   logic                          wvalid;
   logic                          wready;

   logic [`AXI4_ID_WIDTH-1:0]     bid;
   logic [1:0]                    bresp;
   logic [`AXI4_USER_WIDTH-1:0]   buser;
   logic                          bvalid;
   logic                          bready;

   logic [`AXI4_ID_WIDTH-1:0]     arid;
   logic [`AXI4_ADDR_WIDTH-1:0]   araddr;
   logic [7:0]                    arlen;
   logic [2:0]                    arsize;
   logic [1:0]                    arburst;
   logic                          arlock;
   logic [3:0]                    arcache;
   logic [2:0]                    arprot;
   logic [3:0]                    arqos;
   logic [3:0]                    arregion;
   logic [`AXI4_USER_WIDTH-1:0]   aruser;
   logic                          arvalid;
   logic                          arready;

   logic [`AXI4_ID_WIDTH-1:0]     rid;
   logic [`AXI4_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                    rresp;
   logic                          rlast;
   logic [`AXI4_USER_WIDTH-1:0]   ruser;
   logic                          rvalid;
   logic                          rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
             awuser, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wuser, wvalid,
      input  wready,
      input  bid, bresp, buser, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
             aruser, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, ruser, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
             awuser, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wuser, wvalid,
      output wready,
      output bid, bresp, buser, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
             aruser, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, ruser, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi4_mem_slave.sv
// AXI4 memory responder: FIXED/INCR/WRAP bursts with byte strobes over a word array,
// with independent write and read state machines.
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

module axi4_mem_slave #(
   parameter int                           MEM_WORDS = 1024,
   parameter logic [`AXI4_ADDR_WIDTH-1:0]  BASE_ADDR = '0
) (
   input logic   aclk,
   input logic   aresetn,
   axi4_if.slave axi
);
   localparam int AW   = `AXI4_ADDR_WIDTH;
   localparam int DW   = `AXI4_DATA_WIDTH;
   localparam int IW   = `AXI4_ID_WIDTH;
   localparam int NB   = DW / 8;
   localparam int BLOG = $clog2(NB);
   localparam int IDXW = $clog2(MEM_WORDS);
   localparam logic [AW:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [AW:0] WIN_HI = WIN_LO + (AW+1)'(MEM_WORDS * NB);

   function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (burst == 2'b11) || (size > 3'(BLOG)) || ((burst == 2'b10) && !wrap_len_ok);
   endfunction

   function automatic logic addr_bad(input logic [AW-1:0] addr);
      return ({1'b0, addr} < WIN_LO) || ({1'b0, addr} >= WIN_HI);
   endfunction

   function automatic logic [IDXW-1:0] word_index(input logic [AW-1:0] addr);
      return IDXW'((addr - BASE_ADDR) >> BLOG);
   endfunction

   // INCR steps from the size-aligned address so unaligned starts realign after beat 0
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
      logic [AW-1:0] step;
      logic [AW-1:0] aligned;
      logic [AW-1:0] wrap_mask;
      logic [AW-1:0] result;
      step      = AW'(1) << size;
      aligned   = addr & ~(step - AW'(1));
      wrap_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
      case (burst)
         2'b00:   result = addr;
         2'b10:   result = (addr & ~wrap_mask) | ((aligned + step) & wrap_mask);
         default: result = aligned + step;
      endcase
      return result;
   endfunction

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [DW-1:0] mem [MEM_WORDS];

   w_state_t      w_state;
   logic [IW-1:0] w_id;
   logic [AW-1:0] w_addr;
   logic [7:0]    w_len;
   logic [7:0]    w_cnt;
   logic [2:0]    w_size;
   logic [1:0]    w_burst;
   logic          w_err;
   logic          awready_q, wready_q, bvalid_q;
   logic [1:0]    bresp_q;
   logic [IW-1:0] bid_q;

   r_state_t      r_state;
   logic [AW-1:0] r_addr;
   logic [7:0]    r_len;
   logic [7:0]    r_cnt;
   logic [2:0]    r_size;
   logic [1:0]    r_burst;
   logic          arready_q, rvalid_q, rlast_q;
   logic [1:0]    rresp_q;
   logic [DW-1:0] rdata_q;
   logic [IW-1:0] rid_q;

   logic w_beat, w_beat_bad, w_final, r_first_bad, r_next_bad;

   assign w_beat      = (w_state == W_DATA) && axi.wvalid && wready_q;
   assign w_beat_bad  = burst_bad(w_len, w_size, w_burst) || addr_bad(w_addr);
   assign w_final     = (w_cnt == w_len);
   assign r_first_bad = burst_bad(axi.arlen, axi.arsize, axi.arburst) || addr_bad(axi.araddr);
   assign r_next_bad  = burst_bad(r_len, r_size, r_burst) || addr_bad(r_addr);

   assign axi.awready = awready_q;
   assign axi.wready  = wready_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bresp   = bresp_q;
   assign axi.bid     = bid_q;
   assign axi.buser   = '0;
   assign axi.arready = arready_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rlast   = rlast_q;
   assign axi.rresp   = rresp_q;
   assign axi.rdata   = rdata_q;
   assign axi.rid     = rid_q;
   assign axi.ruser   = '0;

   wire unused_ok = &{1'b0, axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion,
                      axi.awuser, axi.wuser, axi.arlock, axi.arcache, axi.arprot, axi.arqos,
                      axi.arregion, axi.aruser};

   // Storage is deliberately not reset; an erroring beat leaves it untouched
   always_ff @(posedge aclk) begin
      if (w_beat && !w_beat_bad) begin
         for (int b = 0; b < NB; b++) begin
            if (axi.wstrb[b]) mem[word_index(w_addr)][b*8 +: 8] <= axi.wdata[b*8 +: 8];
         end
      end
   end

   // wlast is checked against the beat counter; any mismatch or bad beat yields SLVERR
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state   <= W_IDLE;
         w_id      <= '0;
         w_addr    <= '0;
         w_len     <= '0;
         w_cnt     <= '0;
         w_size    <= '0;
         w_burst   <= '0;
         w_err     <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         bid_q     <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (axi.awvalid && awready_q) begin
                  w_id      <= axi.awid;
                  w_addr    <= axi.awaddr;
                  w_len     <= axi.awlen;
                  w_size    <= axi.awsize;
                  w_burst   <= axi.awburst;
                  w_cnt     <= '0;
                  w_err     <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  w_state   <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_beat) begin
                  w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                  w_cnt  <= w_cnt + 8'd1;
                  if (w_final) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bid_q    <= w_id;
                     bresp_q  <= (w_err || w_beat_bad || !axi.wlast) ? 2'b10 : 2'b00;
                     w_state  <= W_RESP;
                  end else if (w_beat_bad || axi.wlast) begin
                     w_err <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // r_addr always holds the address of the beat to present after the current one
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= R_IDLE;
         r_addr    <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         rid_q     <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (axi.arvalid && arready_q) begin
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rid_q     <= axi.arid;
                  rdata_q   <= r_first_bad ? '0 : mem[word_index(axi.araddr)];
                  rresp_q   <= r_first_bad ? 2'b10 : 2'b00;
                  rlast_q   <= (axi.arlen == 8'd0);
                  r_addr    <= next_addr(axi.araddr, axi.arlen, axi.arsize, axi.arburst);
                  r_len     <= axi.arlen;
                  r_size    <= axi.arsize;
                  r_burst   <= axi.arburst;
                  r_cnt     <= '0;
                  r_state   <= R_DATA;
               end
            end
            R_DATA: begin
               if (axi.rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state   <= R_IDLE;
                  end else begin
                     rdata_q <= r_next_bad ? '0 : mem[word_index(r_addr)];
                     rresp_q <= r_next_bad ? 2'b10 : 2'b00;
                     rlast_q <= ((r_cnt + 8'd1) == r_len);
                     r_cnt   <= r_cnt + 8'd1;
                     r_addr  <= next_addr(r_addr, r_len, r_size, r_burst);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: a byte-level memory model predicts every B and R beat,
// and a negedge monitor compares the DUT against it.
module tb_axi4_mem_slave;
   localparam int MEM_WORDS = 256;
   localparam int WIN_BYTES = MEM_WORDS * 4;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_beat_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   logic aclk    = 1'b0;
   logic aresetn = 1'b1;
   always #5 aclk = ~aclk;

   axi4_if axi();

   axi4_mem_slave #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0)) dut (
      .aclk(aclk), .aresetn(aresetn), .axi(axi)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  model_mem [WIN_BYTES];
   r_beat_t     r_exp [$];
   b_exp_t      b_exp [$];
   logic [31:0] wd_tab [32];
   logic [3:0]  ws_tab [32];
   logic [31:0] got_data [32];
   logic [1:0]  got_resp [32];
   logic        got_last [32];
   logic [1:0]  got_bresp;
   logic [3:0]  got_bid;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic report_timeout(input string name);
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s: handshake never came, expected within the cycle budget", name);
   endtask

   // Model: beat address straight from the burst definition, not from a running register
   function automatic int beat_addr(input int start, input int len, input int size,
                                    input int burst, input int i);
      int nb;
      int w;
      int lower;
      nb = 1 << size;
      if (burst == 0) return start;
      if (burst == 2) begin
         w     = (len + 1) * nb;
         lower = start - (start % w);
         return lower + ((start - lower) + i * nb) % w;
      end
      return (i == 0) ? start : (start - (start % nb)) + i * nb;
   endfunction

   function automatic bit burst_err(input int len, input int size, input int burst);
      return (burst == 3) || (size > 2) ||
             ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   function automatic bit in_range(input int a);
      return (a >= 0) && (a < WIN_BYTES);
   endfunction

   function automatic logic [31:0] model_word(input int a);
      int base;
      base = (a / 4) * 4;
      return {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
   endfunction

   task automatic model_write(input int a, input logic [31:0] data, input logic [3:0] strb);
      int base;
      base = (a / 4) * 4;
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) model_mem[base+k] = data[k*8 +: 8];
      end
   endtask

   task automatic apply_stimulus_write(input int id, input int addr, input int len, input int size,
                                       input int burst, input int last_at);
      int  lim;
      int  a;
      bit  any_err;
      @(posedge aclk); #1;
      axi.awvalid = 1'b1;
      axi.awid    = 4'(id);
      axi.awaddr  = 32'(addr);
      axi.awlen   = 8'(len);
      axi.awsize  = 3'(size);
      axi.awburst = 2'(burst);
      lim = 0;
      @(negedge aclk);
      while (!axi.awready && lim < 50) begin @(negedge aclk); lim++; end
      if (!axi.awready) report_timeout("aw_handshake");
      @(posedge aclk); #1;
      axi.awvalid = 1'b0;
      any_err = burst_err(len, size, burst);
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, len, size, burst, i);
         axi.wvalid = 1'b1;
         axi.wdata  = wd_tab[i];
         axi.wstrb  = ws_tab[i];
         axi.wlast  = (i == last_at);
         lim = 0;
         @(negedge aclk);
         while (!axi.wready && lim < 50) begin @(negedge aclk); lim++; end
         if (!axi.wready) report_timeout("w_handshake");
         if ((i == len) != (i == last_at)) any_err = 1'b1;
         if (burst_err(len, size, burst) || !in_range(a)) any_err = 1'b1;
         else model_write(a, wd_tab[i], ws_tab[i]);
         @(posedge aclk); #1;
      end
      axi.wvalid = 1'b0;
      axi.wlast  = 1'b0;
      b_exp.push_back('{id: 4'(id), resp: (any_err ? 2'b10 : 2'b00)});
      axi.bready = 1'b1;
      lim = 0;
      @(negedge aclk);
      while (!axi.bvalid && lim < 50) begin @(negedge aclk); lim++; end
      if (!axi.bvalid) report_timeout("b_handshake");
      got_bresp = axi.bresp;
      got_bid   = axi.bid;
      @(posedge aclk); #1;
      axi.bready = 1'b0;
   endtask

   task automatic apply_stimulus_read(input int id, input int addr, input int len, input int size,
                                      input int burst, input bit toggle, input int stop_after);
      int lim;
      int a;
      int got;
      int cyc;
      bit bad;
      for (int i = 0; i <= len; i++) begin
         a   = beat_addr(addr, len, size, burst, i);
         bad = burst_err(len, size, burst) || !in_range(a);
         r_exp.push_back('{id: 4'(id), data: (bad ? 32'h0 : model_word(a)),
                           resp: (bad ? 2'b10 : 2'b00), last: (i == len)});
      end
      @(posedge aclk); #1;
      axi.arvalid = 1'b1;
      axi.arid    = 4'(id);
      axi.araddr  = 32'(addr);
      axi.arlen   = 8'(len);
      axi.arsize  = 3'(size);
      axi.arburst = 2'(burst);
      lim = 0;
      @(negedge aclk);
      while (!axi.arready && lim < 50) begin @(negedge aclk); lim++; end
      if (!axi.arready) report_timeout("ar_handshake");
      check_output("r_pre_valid", 32'(axi.rvalid), 32'd0);
      @(posedge aclk); #1;
      axi.arvalid = 1'b0;
      got = 0;
      cyc = 0;
      while (got < stop_after && cyc < 200) begin
         axi.rready = toggle ? (cyc % 2 == 0) : 1'b1;
         @(negedge aclk);
         if (cyc == 0) check_output("r_latency", 32'(axi.rvalid), 32'd1);
         if (axi.rvalid && axi.rready) begin
            got_data[got] = axi.rdata;
            got_resp[got] = axi.rresp;
            got_last[got] = axi.rlast;
            got++;
         end
         @(posedge aclk); #1;
         cyc++;
      end
      if (got < stop_after) report_timeout("r_beats");
      if (stop_after == len + 1) begin
         axi.rready = 1'b0;
         @(negedge aclk);
         check_output("r_done_rvalid", 32'(axi.rvalid), 32'd0);
         check_output("r_done_arready", 32'(axi.arready), 32'd1);
      end
   endtask

   // Monitor: every B/R handshake is matched against the model queues; stalled R beats must hold
   r_beat_t     cmp_r;
   b_exp_t      cmp_b;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic [1:0]  prev_resp;
   logic        prev_last;

   always @(negedge aclk) begin
      if (!aresetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_output("r_hold_valid", 32'(axi.rvalid), 32'd1);
            check_output("r_hold_data", axi.rdata, prev_data);
            check_output("r_hold_resp", 32'(axi.rresp), 32'(prev_resp));
            check_output("r_hold_last", 32'(axi.rlast), 32'(prev_last));
         end
         if (axi.rvalid && axi.rready) begin
            if (r_exp.size() == 0) begin
               n_vec++;
               n_err++;
               $display("[TB] FAIL r_unexpected: got beat 0x%08h, expected no beat", axi.rdata);
            end else begin
               cmp_r = r_exp.pop_front();
               check_output("r_id", 32'(axi.rid), 32'(cmp_r.id));
               check_output("r_data", axi.rdata, cmp_r.data);
               check_output("r_resp", 32'(axi.rresp), 32'(cmp_r.resp));
               check_output("r_last", 32'(axi.rlast), 32'(cmp_r.last));
            end
         end
         prev_stall = axi.rvalid && !axi.rready;
         prev_data  = axi.rdata;
         prev_resp  = axi.rresp;
         prev_last  = axi.rlast;
         if (axi.bvalid && axi.bready) begin
            if (b_exp.size() == 0) begin
               n_vec++;
               n_err++;
               $display("[TB] FAIL b_unexpected: got bresp %0d, expected no response", axi.bresp);
            end else begin
               cmp_b = b_exp.pop_front();
               check_output("b_id", 32'(axi.bid), 32'(cmp_b.id));
               check_output("b_resp", 32'(axi.bresp), 32'(cmp_b.resp));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected one before the time limit");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      for (int i = 0; i < WIN_BYTES; i++) model_mem[i] = 8'h00;
      {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
       axi.awprot, axi.awqos, axi.awregion, axi.awuser, axi.awvalid} = '0;
      {axi.wdata, axi.wstrb, axi.wlast, axi.wuser, axi.wvalid, axi.bready} = '0;
      {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache,
       axi.arprot, axi.arqos, axi.arregion, axi.aruser, axi.arvalid, axi.rready} = '0;

      // Reset values
      #1 aresetn = 1'b0;
      #2;
      check_output("rst_awready", 32'(axi.awready), 32'd0);
      check_output("rst_wready", 32'(axi.wready), 32'd0);
      check_output("rst_bvalid", 32'(axi.bvalid), 32'd0);
      check_output("rst_bresp", 32'(axi.bresp), 32'd0);
      check_output("rst_bid", 32'(axi.bid), 32'd0);
      check_output("rst_arready", 32'(axi.arready), 32'd0);
      check_output("rst_rvalid", 32'(axi.rvalid), 32'd0);
      check_output("rst_rlast", 32'(axi.rlast), 32'd0);
      check_output("rst_rresp", 32'(axi.rresp), 32'd0);
      check_output("rst_rdata", axi.rdata, 32'd0);
      check_output("rst_rid", 32'(axi.rid), 32'd0);
      #19 aresetn = 1'b1;
      #1;
      check_output("rel_awready_before_edge", 32'(axi.awready), 32'd0);
      @(negedge aclk);
      check_output("rel_awready", 32'(axi.awready), 32'd1);
      check_output("rel_arready", 32'(axi.arready), 32'd1);

      // Preload words 0x00..0x7C with 0x1000_0000 + word index
      for (int i = 0; i < 32; i++) begin wd_tab[i] = 32'h1000_0000 + 32'(i); ws_tab[i] = 4'hF; end
      apply_stimulus_write(1, 'h00, 31, 2, 1, 31);
      check_output("fill_bresp", 32'(got_bresp), 32'd0);

      // Single write and read-back
      wd_tab[0] = 32'hDEAD_BEEF; ws_tab[0] = 4'hF;
      apply_stimulus_write(5, 'h10, 0, 2, 1, 0);
      check_output("t1_bresp", 32'(got_bresp), 32'd0);
      check_output("t1_bid", 32'(got_bid), 32'd5);
      apply_stimulus_read(6, 'h10, 0, 2, 1, 1'b0, 1);
      check_output("t1_rdata", got_data[0], 32'hDEAD_BEEF);
      check_output("t1_rlast", 32'(got_last[0]), 32'd1);
      check_output("t1_rresp", 32'(got_resp[0]), 32'd0);

      // INCR burst, read back with rready toggling
      for (int i = 0; i < 4; i++) wd_tab[i] = 32'(i + 1);
      apply_stimulus_write(2, 'h20, 3, 2, 1, 3);
      apply_stimulus_read(3, 'h20, 3, 2, 1, 1'b1, 4);
      for (int i = 0; i < 4; i++) begin
         check_output("t2_rdata", got_data[i], 32'(i + 1));
         check_output("t2_rlast", 32'(got_last[i]), 32'(i == 3));
      end

      // WRAP: 0x38,0x3C,0x30,0x34; illegal len=2 errors every beat
      apply_stimulus_read(4, 'h38, 3, 2, 2, 1'b0, 4);
      check_output("t3_wrap0", got_data[0], 32'h1000_000E);
      check_output("t3_wrap1", got_data[1], 32'h1000_000F);
      check_output("t3_wrap2", got_data[2], 32'h1000_000C);
      check_output("t3_wrap3", got_data[3], 32'h1000_000D);
      apply_stimulus_read(4, 'h38, 2, 2, 2, 1'b0, 3);
      for (int i = 0; i < 3; i++) begin
         check_output("t3_badwrap_resp", 32'(got_resp[i]), 32'd2);
         check_output("t3_badwrap_data", got_data[i], 32'd0);
      end

      // Byte strobes and a narrow write
      wd_tab[0] = 32'h0; ws_tab[0] = 4'hF;
      apply_stimulus_write(1, 'h48, 0, 2, 1, 0);
      wd_tab[0] = 32'hAABB_CCDD; ws_tab[0] = 4'h5;
      apply_stimulus_write(1, 'h48, 0, 2, 1, 0);
      apply_stimulus_read(1, 'h48, 0, 2, 1, 1'b0, 1);
      check_output("t4_strobe", got_data[0], 32'h00BB_00DD);
      wd_tab[0] = 32'h7E00_0000; ws_tab[0] = 4'h8;
      apply_stimulus_write(1, 'h43, 0, 0, 1, 0);
      apply_stimulus_read(1, 'h40, 0, 2, 1, 1'b0, 1);
      check_output("t4_narrow", got_data[0], 32'h7E00_0010);

      // Error responses
      wd_tab[0] = 32'h1234_5678; ws_tab[0] = 4'hF;
      apply_stimulus_write(9, 'h400, 0, 2, 1, 0);
      check_output("t5_oor_bresp", 32'(got_bresp), 32'd2);
      apply_stimulus_read(9, 'h00, 0, 2, 1, 1'b0, 1);
      check_output("t5_no_alias", got_data[0], 32'h1000_0000);
      for (int i = 0; i < 4; i++) begin wd_tab[i] = 32'hA0 + 32'(i); ws_tab[i] = 4'hF; end
      apply_stimulus_write(2, 'h50, 3, 2, 1, 2);
      check_output("t5_wlast_bresp", 32'(got_bresp), 32'd2);
      wd_tab[0] = 32'hCAFE_F00D;
      apply_stimulus_write(3, 'h3FC, 0, 2, 1, 0);
      apply_stimulus_read(3, 'h3FC, 1, 2, 1, 1'b0, 2);
      check_output("t5_edge_resp0", 32'(got_resp[0]), 32'd0);
      check_output("t5_edge_data0", got_data[0], 32'hCAFE_F00D);
      check_output("t5_edge_resp1", 32'(got_resp[1]), 32'd2);
      check_output("t5_edge_data1", got_data[1], 32'd0);

      // Reset in the middle of an 8-beat read
      apply_stimulus_read(7, 'h00, 7, 2, 1, 1'b0, 2);
      axi.rready = 1'b0;
      #1;
      check_output("t6_pre_rvalid", 32'(axi.rvalid), 32'd1);
      aresetn = 1'b0;
      r_exp.delete();
      #1;
      check_output("t6_rst_rvalid", 32'(axi.rvalid), 32'd0);
      check_output("t6_rst_rdata", axi.rdata, 32'd0);
      check_output("t6_rst_arready", 32'(axi.arready), 32'd0);
      repeat (2) @(posedge aclk);
      #2 aresetn = 1'b1;
      @(negedge aclk);
      check_output("t6_arready_no_edge", 32'(axi.arready), 32'd0);
      @(negedge aclk);
      check_output("t6_arready_one_edge", 32'(axi.arready), 32'd1);
      apply_stimulus_read(8, 'h10, 0, 2, 1, 1'b0, 1);
      check_output("t6_after_rdata", got_data[0], 32'hDEAD_BEEF);
      check_output("t6_after_rlast", 32'(got_last[0]), 32'd1);

      repeat (2) @(posedge aclk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
